// File: rtl/seq_pkg.sv
// Shared state encoding and prescaler speed codes for the pattern sequencer.
// The SEQ_PINGPONG_EN macro is consumed by seq_addr_gen and pattern_sequencer, not here.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   localparam logic [2:0] SPEED_SIM  = 3'b000;
   localparam logic [2:0] SPEED_50HZ = 3'b001;
   localparam logic [2:0] SPEED_20HZ = 3'b010;
   localparam logic [2:0] SPEED_10HZ = 3'b011;
   localparam logic [2:0] SPEED_5HZ  = 3'b100;
   localparam logic [2:0] SPEED_2HZ  = 3'b101;
   localparam logic [2:0] SPEED_1HZ  = 3'b110;

endpackage

// File: rtl/seq_addr_gen.sv
// Pattern RAM address pointer: latches the play window on load and advances on step.
// With SEQ_PINGPONG_EN defined it adds a pingpong input and a direction register.
module seq_addr_gen #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              loop,
`ifdef SEQ_PINGPONG_EN
   input  logic              pingpong,
`endif
   output logic [ADDR_W-1:0] ptr,
   output logic              at_end
);

   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [ADDR_W-1:0] first_reg, last_reg;
   logic              loop_reg;
`ifdef SEQ_PINGPONG_EN
   logic              pp_reg;
   logic              down_reg, down_next;
`endif

   always_comb begin
      ptr_next = ptr_reg;
`ifdef SEQ_PINGPONG_EN
      down_next = down_reg;
`endif
      if (load) begin
         ptr_next = first_addr;
`ifdef SEQ_PINGPONG_EN
         down_next = 1'b0;
`endif
      end else if (step) begin
`ifdef SEQ_PINGPONG_EN
         // Endpoints are visited once per sweep; a one-word window just stays put.
         if (loop_reg && pp_reg) begin
            if (!down_reg) begin
               if (ptr_reg != last_reg)
                  ptr_next = ptr_reg + ADDR_W'(1);
               else if (first_reg != last_reg) begin
                  ptr_next  = ptr_reg - ADDR_W'(1);
                  down_next = 1'b1;
               end
            end else begin
               if (ptr_reg != first_reg)
                  ptr_next = ptr_reg - ADDR_W'(1);
               else begin
                  ptr_next  = ptr_reg + ADDR_W'(1);
                  down_next = 1'b0;
               end
            end
         end else
`endif
         if (ptr_reg != last_reg)
            ptr_next = ptr_reg + ADDR_W'(1);
         else if (loop_reg)
            ptr_next = first_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg   <= '0;
         first_reg <= '0;
         last_reg  <= '0;
         loop_reg  <= 1'b0;
`ifdef SEQ_PINGPONG_EN
         pp_reg    <= 1'b0;
         down_reg  <= 1'b0;
`endif
      end else begin
         ptr_reg <= ptr_next;
`ifdef SEQ_PINGPONG_EN
         down_reg <= down_next;
`endif
         if (load) begin
            first_reg <= first_addr;
            last_reg  <= last_addr;
            loop_reg  <= loop;
`ifdef SEQ_PINGPONG_EN
            pp_reg    <= pingpong;
`endif
         end
      end
   end

   assign ptr = ptr_reg;
   // Only a one-shot run ends at last; looping runs never report an end.
   assign at_end = (ptr_reg == last_reg) && !loop_reg;

endmodule

// File: rtl/pattern_sequencer.sv
// Plays a stored pattern out of a synchronous-read RAM, one word per prescaler tick.
// Defining SEQ_PINGPONG_EN adds the pingpong input (bounce between first and last).
module pattern_sequencer
   import seq_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
`ifdef SEQ_PINGPONG_EN
   input  logic              pingpong,
`endif
   input  logic [2:0]        speed_sel,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              tick_in,
   output logic              presc_rst_n,
   output logic [2:0]        speed,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pattern,
   output logic              pattern_valid,
   output logic              busy,
   output logic              done
);

   seq_state_t        state_reg;
   logic [2:0]        speed_reg;
   logic              presc_reg, busy_reg, done_reg, valid_reg;
   logic [DATA_W-1:0] hold_reg;
   logic [ADDR_W-1:0] ptr;
   logic              at_end;
   logic              rd_fire;
   logic              load;

   // Stop wins over a coincident tick.
   assign rd_fire = (state_reg == RUN) && tick_in && !stop;
   assign load    = (state_reg == IDLE) && start;

   seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .step       (rd_fire),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .loop       (loop),
`ifdef SEQ_PINGPONG_EN
      .pingpong   (pingpong),
`endif
      .ptr        (ptr),
      .at_end     (at_end)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         speed_reg <= '0;
         presc_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         valid_reg <= 1'b0;
         hold_reg  <= '0;
      end else begin
         valid_reg <= rd_fire;
         done_reg  <= 1'b0;
         if (valid_reg)
            hold_reg <= rd_data;
         unique case (state_reg)
            IDLE: if (start) begin
               state_reg <= ARM;
               speed_reg <= speed_sel;
               presc_reg <= 1'b1;
               busy_reg  <= 1'b1;
            end
            ARM: if (stop) begin
               state_reg <= IDLE;
               presc_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end else begin
               state_reg <= RUN;
            end
            RUN: if (stop) begin
               state_reg <= IDLE;
               presc_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end else if (rd_fire && at_end) begin
               state_reg <= DONE;
               presc_reg <= 1'b0;
               done_reg  <= 1'b1;
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign presc_rst_n   = presc_reg;
   assign speed         = speed_reg;
   assign rd_en         = rd_fire;
   assign rd_addr       = ptr;
   // The RAM word is only valid the cycle after rd_en, so it is passed straight
   // through alongside the strobe and held in hold_reg afterwards.
   assign pattern       = valid_reg ? rd_data : hold_reg;
   assign pattern_valid = valid_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a toy prescaler and a RAM holding mem[i]=i*16.
// The pingpong scenario is compiled in only when SEQ_PINGPONG_EN is defined.
module tb_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop = 1'b0;
   logic [2:0] speed_sel = 3'b000;
   logic [3:0] first_addr = 4'd0;
   logic [3:0] last_addr = 4'd0;
   logic       tick_in;
   logic       presc_rst_n;
   logic [2:0] speed;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] pattern;
   logic       pattern_valid;
   logic       busy;
   logic       done;
`ifdef SEQ_PINGPONG_EN
   logic       pingpong_v = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mem [0:15];
   logic       presc_cnt = 1'b0;

   always #5 clk = ~clk;

   // Prescaler model: SIM ticks every cycle, any other code every second cycle.
   always @(posedge clk) presc_cnt <= presc_rst_n ? ~presc_cnt : 1'b0;
   assign tick_in = presc_rst_n && ((speed == 3'b000) || presc_cnt);

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   pattern_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stop          (stop),
      .loop          (loop),
`ifdef SEQ_PINGPONG_EN
      .pingpong      (pingpong_v),
`endif
      .speed_sel     (speed_sel),
      .first_addr    (first_addr),
      .last_addr     (last_addr),
      .tick_in       (tick_in),
      .presc_rst_n   (presc_rst_n),
      .speed         (speed),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .pattern       (pattern),
      .pattern_valid (pattern_valid),
      .busy          (busy),
      .done          (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // One run at SPEED_SIM: exp_a lists the expected read addresses; stop is raised
   // in read slot stop_at (99 = never); poke keeps start high while busy.
   task automatic play(input string tag, input logic [3:0] f, input logic [3:0] l,
                       input logic lp, input int n, input logic [3:0] exp_a [0:15],
                       input int stop_at, input logic poke);
      logic [7:0] last_word;
      adv();
      start = 1'b1; first_addr = f; last_addr = l; loop = lp; speed_sel = 3'b000;
      settle();
      chk({tag, ".idle_busy"}, busy, 0);
      adv();
      start = poke;
      settle();
      chk({tag, ".arm_busy"}, busy, 1);
      chk({tag, ".arm_presc"}, presc_rst_n, 1);
      chk({tag, ".arm_rd_en"}, rd_en, 0);
      for (int k = 0; k < n; k++) begin
         adv();
         start = poke;
         stop = (k == stop_at);
         settle();
         if (k == stop_at) begin
            last_word = {exp_a[k-1], 4'h0};
            chk({tag, ".stop_tick"}, tick_in, 1);
            chk({tag, ".stop_rd_en"}, rd_en, 0);
            chk({tag, ".stop_valid"}, pattern_valid, 1);
            chk({tag, ".stop_pattern"}, pattern, last_word);
            $display("%s stop: trailing pattern=%02h", tag, pattern);
            break;
         end
         chk({tag, ".rd_en"}, rd_en, 1);
         chk({tag, ".rd_addr"}, rd_addr, exp_a[k]);
         if (k > 0) begin
            last_word = {exp_a[k-1], 4'h0};
            chk({tag, ".valid"}, pattern_valid, 1);
            chk({tag, ".pattern"}, pattern, last_word);
         end
         $display("%s read %0d: addr=%0d", tag, k, rd_addr);
      end
      if (stop_at >= 0 && stop_at < n) begin
         adv();
         stop = 1'b0; start = 1'b0;
         settle();
         chk({tag, ".post_stop_busy"}, busy, 0);
         chk({tag, ".post_stop_rd_en"}, rd_en, 0);
         chk({tag, ".post_stop_valid"}, pattern_valid, 0);
         chk({tag, ".post_stop_presc"}, presc_rst_n, 0);
      end else begin
         last_word = {exp_a[n-1], 4'h0};
         adv();
         start = poke;
         settle();
         chk({tag, ".done"}, done, 1);
         chk({tag, ".done_valid"}, pattern_valid, 1);
         chk({tag, ".done_pattern"}, pattern, last_word);
         chk({tag, ".done_rd_en"}, rd_en, 0);
         chk({tag, ".done_presc"}, presc_rst_n, 0);
         chk({tag, ".done_busy"}, busy, 1);
         $display("%s done: pattern=%02h", tag, pattern);
         adv();
         start = 1'b0;
         settle();
         chk({tag, ".idle_done"}, done, 0);
         chk({tag, ".idle_busy2"}, busy, 0);
         chk({tag, ".idle_presc"}, presc_rst_n, 0);
         chk({tag, ".idle_valid"}, pattern_valid, 0);
         chk({tag, ".held_pattern"}, pattern, last_word);
         adv();
         settle();
         chk({tag, ".stay_idle"}, busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ea [0:15];
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 16);

      adv(); adv();
      settle();
      chk("rst.busy", busy, 0);
      chk("rst.presc", presc_rst_n, 0);
      chk("rst.rd_en", rd_en, 0);
      chk("rst.pattern", pattern, 0);
      chk("rst.valid", pattern_valid, 0);
      chk("rst.done", done, 0);
      chk("rst.speed", speed, 0);
      adv();
      rst_n = 1'b1;

      ea = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T1", 4'd2, 4'd5, 1'b0, 4, ea, 99, 1'b0);

      ea = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T2", 4'd14, 4'd1, 1'b1, 7, ea, 6, 1'b0);

      ea = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T3", 4'd0, 4'd3, 1'b1, 3, ea, 2, 1'b0);

      // T4: slow speed, reset for one edge in the middle of the run.
      adv();
      start = 1'b1; first_addr = 4'd9; last_addr = 4'd12; loop = 1'b1; speed_sel = 3'b110;
      settle();
      adv();
      start = 1'b0;
      settle();
      chk("T4.arm_speed", speed, 3'b110);
      chk("T4.arm_rd_en", rd_en, 0);
      adv();
      settle();
      chk("T4.r1_rd_en", rd_en, 1);
      chk("T4.r1_addr", rd_addr, 9);
      adv();
      settle();
      chk("T4.hold_rd_en", rd_en, 0);
      chk("T4.hold_valid", pattern_valid, 1);
      chk("T4.hold_pattern", pattern, 8'h90);
      adv();
      rst_n = 1'b0;
      settle();
      chk("T4.r2_rd_en", rd_en, 1);
      chk("T4.r2_addr", rd_addr, 10);
      adv();
      rst_n = 1'b1;
      settle();
      chk("T4.rst_busy", busy, 0);
      chk("T4.rst_presc", presc_rst_n, 0);
      chk("T4.rst_speed", speed, 0);
      chk("T4.rst_pattern", pattern, 0);
      chk("T4.rst_valid", pattern_valid, 0);
      chk("T4.rst_rd_en", rd_en, 0);
      chk("T4.rst_rd_addr", rd_addr, 0);
      chk("T4.rst_done", done, 0);
      $display("T4 reset mid-run: busy=%0d pattern=%02h", busy, pattern);
      ea = '{4'd9, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T4b", 4'd9, 4'd10, 1'b0, 2, ea, 99, 1'b0);

      ea = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T5", 4'd7, 4'd7, 1'b0, 1, ea, 99, 1'b1);

`ifdef SEQ_PINGPONG_EN
      pingpong_v = 1'b1;
      ea = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd4, 4'd5, 4'd0,
             4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      play("T6", 4'd3, 4'd5, 1'b1, 8, ea, 7, 1'b0);
      pingpong_v = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
